// File: rtl/id_inst_queue_pkg.sv
// id_inst_queue_pkg: shared constants for the ID instruction queue
`ifndef INST_NOP
`define INST_NOP 32'h0000_0000
`endif
`ifndef IQ_MAX_SHADOW
`define IQ_MAX_SHADOW 7
`endif

package id_inst_queue_pkg;
  localparam logic [31:0] INST_NOP      = `INST_NOP;
  localparam int          IQ_MAX_SHADOW = `IQ_MAX_SHADOW;
  localparam int          SHADOW_W      = $clog2(IQ_MAX_SHADOW + 1);
endpackage

// File: rtl/id_inst_queue_storage.sv
// iq_storage: unreset register array with one write port and an async read port
module iq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  // write the addressed entry; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/id_inst_queue.sv
// id_inst_queue: FIFO of {pc, inst} between Icache responses and ID decode
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int INST_W       = 32,
  parameter int PC_W         = 32,
  parameter bit BYPASS       = 1'b1,
  parameter int FLUSH_SHADOW = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       icache_valid_i,
  input  logic [INST_W-1:0]          icache_inst_i,
  input  logic [PC_W-1:0]            icache_pc_i,
  output logic                       iq_ready_o,
  input  logic                       fc_bk_i,
  input  logic                       fc_flush_i,
  output logic                       iq_valid_o,
  output logic [INST_W-1:0]          iq_inst_o,
  output logic [PC_W-1:0]            iq_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] iq_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [SHADOW_W-1:0] SHADOW_LOAD = SHADOW_W'(FLUSH_SHADOW);

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                empty, full, resp_ok, byp, bypass_take, push, pop, pop_mem;
  logic [PC_W+INST_W-1:0] head;

  assign empty       = count_q == '0;
  assign full        = count_q == CW'(DEPTH);
  // a response counts only outside reset, flush and the post-flush shadow
  assign resp_ok     = rst_n && icache_valid_i && !fc_flush_i && shadow_q == '0;
  assign byp         = BYPASS && empty && resp_ok;
  assign bypass_take = byp && !fc_bk_i;
  assign iq_valid_o  = !fc_flush_i && (!empty || byp);
  assign pop         = iq_valid_o && !fc_bk_i;
  assign pop_mem     = pop && !empty;
  assign iq_ready_o  = !full || pop;
  assign push        = resp_ok && iq_ready_o && !bypass_take;
  assign iq_count_o  = count_q;

  iq_storage #(.DEPTH(DEPTH), .W(PC_W + INST_W)) u_storage (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({icache_pc_i, icache_inst_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // present stored head, else the bypassed response, else NOP/0
  always_comb begin
    iq_pc_o   = !iq_valid_o ? '0 : empty ? icache_pc_i : head[PC_W+INST_W-1:INST_W];
    iq_inst_o = !iq_valid_o ? INST_W'(INST_NOP) : empty ? icache_inst_i : head[INST_W-1:0];
  end

  // next-state: flush clears the queue and arms the shadow counter
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = fc_flush_i ? wr_ptr_q : rd_ptr_q + AW'(pop_mem);
    count_d  = fc_flush_i ? '0 : count_q + CW'(push) - CW'(pop_mem);
    shadow_d = fc_flush_i ? SHADOW_LOAD : shadow_q != '0 ? shadow_q - 1'b1 : '0;
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue: directed self-checking bench for id_inst_queue
module tb_id_inst_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_valid_i;
  logic [31:0] icache_inst_i;
  logic [31:0] icache_pc_i;
  logic        iq_ready_o;
  logic        fc_bk_i;
  logic        fc_flush_i;
  logic        iq_valid_o;
  logic [31:0] iq_inst_o;
  logic [31:0] iq_pc_o;
  logic [2:0]  iq_count_o;
  int          n_cmp = 0;
  int          n_err = 0;

  id_inst_queue #(.DEPTH(4), .INST_W(32), .PC_W(32), .BYPASS(1'b1), .FLUSH_SHADOW(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_valid_i (icache_valid_i),
    .icache_inst_i  (icache_inst_i),
    .icache_pc_i    (icache_pc_i),
    .iq_ready_o     (iq_ready_o),
    .fc_bk_i        (fc_bk_i),
    .fc_flush_i     (fc_flush_i),
    .iq_valid_o     (iq_valid_o),
    .iq_inst_o      (iq_inst_o),
    .iq_pc_o        (iq_pc_o),
    .iq_count_o     (iq_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic bk, input logic fl);
    icache_valid_i = v;
    icache_pc_i    = pc;
    icache_inst_i  = 32'hA000_0000 | pc;
    fc_bk_i        = bk;
    fc_flush_i     = fl;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_valid", 32'(iq_valid_o), 32'd0);
    chk("rst_inst", iq_inst_o, 32'h0);
    chk("rst_pc", iq_pc_o, 32'h0);
    chk("rst_ready", 32'(iq_ready_o), 32'd1);
    chk("rst_count", 32'(iq_count_o), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    icache_valid_i = 1'b1;
    icache_pc_i    = 32'h100;
    icache_inst_i  = 32'h0050_0093;
    fc_bk_i        = 1'b0;
    fc_flush_i     = 1'b0;
    #2;
    chk("byp_valid", 32'(iq_valid_o), 32'd1);
    chk("byp_pc", iq_pc_o, 32'h100);
    chk("byp_inst", iq_inst_o, 32'h0050_0093);
    chk("byp_count", 32'(iq_count_o), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("byp_after_count", 32'(iq_count_o), 32'd0);
    chk("byp_after_valid", 32'(iq_valid_o), 32'd0);

    fill(32'h0, 4);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_count", 32'(iq_count_o), 32'd4);
    chk("stall_ready", 32'(iq_ready_o), 32'd0);
    chk("stall_pc", iq_pc_o, 32'h0);
    chk("stall_valid", 32'(iq_valid_o), 32'd1);
    tick();
    chk("stall_hold_pc", iq_pc_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("drain_valid", 32'(iq_valid_o), 32'd1);
      chk("drain_pc", iq_pc_o, 32'(4 * i));
      chk("drain_inst", iq_inst_o, 32'hA000_0000 | 32'(4 * i));
      tick();
    end
    chk("drain_empty", 32'(iq_valid_o), 32'd0);
    chk("drain_count", 32'(iq_count_o), 32'd0);

    fill(32'h0, 4);
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 32'h10 + 32'(4 * k), 1'b0, 1'b0);
      chk("full_ready", 32'(iq_ready_o), 32'd1);
      chk("full_pc", iq_pc_o, 32'(4 * k));
      chk("full_count", 32'(iq_count_o), 32'd4);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("wrap_pc", iq_pc_o, 32'h2C + 32'(4 * k));
      tick();
    end
    chk("wrap_empty", 32'(iq_valid_o), 32'd0);

    fill(32'h40, 3);
    drive(1'b1, 32'h50, 1'b0, 1'b1);
    chk("fl_valid", 32'(iq_valid_o), 32'd0);
    chk("fl_inst", iq_inst_o, 32'h0);
    tick();
    drive(1'b1, 32'h54, 1'b0, 1'b0);
    chk("fl_count", 32'(iq_count_o), 32'd0);
    chk("shadow_valid", 32'(iq_valid_o), 32'd0);
    tick();
    chk("shadow_count", 32'(iq_count_o), 32'd0);
    drive(1'b1, 32'h58, 1'b1, 1'b0);
    chk("post_shadow_valid", 32'(iq_valid_o), 32'd1);
    chk("post_shadow_pc", iq_pc_o, 32'h58);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_shadow_count", 32'(iq_count_o), 32'd1);
    chk("post_shadow_head", iq_pc_o, 32'h58);
    tick();
    chk("post_shadow_empty", 32'(iq_valid_o), 32'd0);

    fill(32'h60, 2);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("flbk_valid", 32'(iq_valid_o), 32'd0);
    chk("flbk_inst", iq_inst_o, 32'h0);
    chk("flbk_pc", iq_pc_o, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("flbk_count", 32'(iq_count_o), 32'd0);
    chk("flbk_valid2", 32'(iq_valid_o), 32'd0);
    tick();

    fill(32'h70, 3);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("mid_count", 32'(iq_count_o), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(iq_valid_o), 32'd0);
    chk("arst_count", 32'(iq_count_o), 32'd0);
    chk("arst_ready", 32'(iq_ready_o), 32'd1);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h80, 1'b1, 1'b0);
    chk("arst_first_pc", iq_pc_o, 32'h80);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("arst_first_count", 32'(iq_count_o), 32'd1);
    chk("arst_first_head", iq_pc_o, 32'h80);
    tick();
    chk("arst_final_empty", 32'(iq_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
